// File: rtl/mem_stage_pkg.sv
// Shared memory-stage definitions: FSM states, opcode field location and
// LDR/STR decode, kept in one place so writeback decodes identically.
package mem_stage_pkg;

    localparam int unsigned OPC_MSB = 27;
    localparam int unsigned OPC_LSB = 21;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 7;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    function automatic logic is_ldr(input logic [OPC_W-1:0] opcode);
        return (opcode[6:4] == 3'b110) || (opcode[6:3] == 4'b1000);
    endfunction

    function automatic logic is_str(input logic [OPC_W-1:0] opcode);
        return (opcode[6:4] == 3'b111) || (opcode[6:3] == 4'b1001);
    endfunction

endpackage

// File: rtl/mem_pipeline_unit.sv
// Capture register for the instruction, PC, effective address and store data
// handed over from execute; loads only when the controller accepts a new op.
module mem_pipeline_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    output logic [INSTR_W-1:0]  instr_q,
    output logic [PC_W-1:0]     pc_q,
    output logic [ADDR_W-1:0]   addr_q,
    output logic [DATA_W-1:0]   wdata_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            instr_q <= instr_in;
            pc_q    <= pc_in;
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: captures one instruction at a time, issues its
// LDR/STR transaction over the req/ready + rvalid handshake, then hands the
// instruction, PC and loaded word to writeback for one cycle.
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                valid_out,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [PC_W-1:0]     pc_out,
    output logic [DATA_W-1:0]   ldr_data_out
);

    mem_state_t          state_q;
    mem_state_t          state_d;
    logic                load;
    logic [OPC_W-1:0]    opc_in;
    logic [OPC_W-1:0]    opc_q;
    logic [DATA_W-1:0]   ldr_data_q;

    assign opc_in       = instr_in[OPC_MSB:OPC_LSB];
    assign opc_q        = instr_out[OPC_MSB:OPC_LSB];
    assign ldr_data_out = ldr_data_q;

    mem_pipeline_unit #(
        .ADDR_W (ADDR_W)
    ) u_capture (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .instr_in (instr_in),
        .pc_in    (pc_in),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .instr_q  (instr_out),
        .pc_q     (pc_out),
        .addr_q   (mem_addr),
        .wdata_q  (mem_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture is allowed in IDLE and in DONE so back-to-back ops lose no cycle.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        valid_out = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                valid_out = (state_q == DONE);
                if (valid_in) begin
                    load    = 1'b1;
                    state_d = (is_ldr(opc_in) || is_str(opc_in)) ? REQ : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_str(opc_q);
                if (mem_ready) begin
                    state_d = is_str(opc_q) ? DONE : RSP;
                end
            end
            RSP: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loaded word: zeroed on every capture, filled only by a response in RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldr_data_q <= '0;
        end else if (load) begin
            ldr_data_q <= '0;
        end else if ((state_q == RSP) && mem_rvalid) begin
            ldr_data_q <= mem_rdata;
        end
    end

endmodule
